// File: rtl/pdiv_gen.sv
// pdiv_gen: routes every DIVISOR-th enabled input pulse to outd_o, the rest to outn_o.
// Define PDIV_PERIOD_MEAS_EN to measure the outd_o period on PERIOD.
module pdiv_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             inp_i,
    input  logic             enable_i,
    output logic             outd_o,
    output logic             outn_o,
    input  logic [CNT_W-1:0] DIVISOR,
    input  logic             DIVISOR_WSTB,
    input  logic [CNT_W-1:0] PHASE,
    input  logic             PHASE_WSTB,
    input  logic             FIRST_PULSE,
    input  logic             FIRST_PULSE_WSTB,
    output logic [CNT_W-1:0] COUNT,
    output logic [CNT_W-1:0] PERIOD
);
    logic [CNT_W-1:0] div_shadow, div_act, phase, last, start, base, cnt_next;
    logic first_pulse, inp_d, enable_d, live, route;
    logic en_rise, hit, wrap, outd_next, outn_next;

    always_comb begin
        last      = div_act - CNT_W'(1);
        start     = first_pulse ? last : (phase > last ? last : phase);
        en_rise   = enable_i & ~enable_d;
        hit       = enable_i & inp_i & ~inp_d;
        // an edge arriving with the enable edge is judged against the start value
        base      = en_rise ? start : COUNT;
        wrap      = hit & (base == last);
        cnt_next  = !enable_i ? COUNT : hit ? (wrap ? '0 : base + CNT_W'(1)) : base;
        outd_next = enable_i & inp_i & (hit ? wrap : live & route);
        outn_next = enable_i & inp_i & (hit ? ~wrap : live & ~route);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_shadow  <= CNT_W'(1);
            div_act     <= CNT_W'(1);
            phase       <= '0;
            first_pulse <= 1'b0;
            inp_d       <= 1'b0;
            enable_d    <= 1'b0;
            COUNT       <= '0;
            live        <= 1'b0;
            route       <= 1'b0;
            outd_o      <= 1'b0;
            outn_o      <= 1'b0;
        end else begin
            inp_d    <= inp_i;
            enable_d <= enable_i;
            if (DIVISOR_WSTB) div_shadow <= (DIVISOR == '0) ? CNT_W'(1) : DIVISOR;
            if (PHASE_WSTB) phase <= PHASE;
            if (FIRST_PULSE_WSTB) first_pulse <= FIRST_PULSE;
            // divisor changes only take effect at a wrap while counting
            if (!enable_i || wrap) div_act <= div_shadow;
            COUNT  <= cnt_next;
            if (hit) route <= wrap;
            live   <= enable_i & inp_i & (hit | live);
            outd_o <= outd_next;
            outn_o <= outn_next;
        end
    end

`ifdef PDIV_PERIOD_MEAS_EN
    logic [CNT_W-1:0] per_cnt;
    logic             seen;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            per_cnt <= '0;
            seen    <= 1'b0;
            PERIOD  <= '0;
        end else begin
            per_cnt <= (&per_cnt) ? per_cnt : per_cnt + CNT_W'(1);
            if (en_rise) begin
                PERIOD <= '0;
                seen   <= 1'b0;
            end
            if (outd_next & ~outd_o) begin
                per_cnt <= CNT_W'(1);
                seen    <= 1'b1;
                if (seen && !en_rise) PERIOD <= per_cnt;
            end
        end
    end
`else
    assign PERIOD = '0;
`endif
endmodule

// File: tb/tb_pdiv_gen.sv
// tb_pdiv_gen: directed tables, corner sequences and random stimulus against a behavioural model.
module tb_pdiv_gen;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0, reset_n = 1'b0, inp = 1'b0, enable = 1'b0;
    logic outd, outn;
    logic [W-1:0] divisor = '0, phase = '0, count, period;
    logic div_wstb = 1'b0, phase_wstb = 1'b0, first = 1'b0, first_wstb = 1'b0;
    int n_checks = 0, n_fail = 0;

    int m_shadow, m_act, m_phase, m_count, m_owner, m_cyc, m_last, m_period;
    bit m_first, m_inp_d, m_en_d, m_outd, m_outn, m_seen;

    typedef struct {int en; int in; int d; int n; int cnt;} vec_t;
    vec_t tbl[19];

    always #5 clk = ~clk;

    pdiv_gen #(.CNT_W(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .inp_i(inp), .enable_i(enable),
        .outd_o(outd), .outn_o(outn),
        .DIVISOR(divisor), .DIVISOR_WSTB(div_wstb),
        .PHASE(phase), .PHASE_WSTB(phase_wstb),
        .FIRST_PULSE(first), .FIRST_PULSE_WSTB(first_wstb),
        .COUNT(count), .PERIOD(period)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = 1; m_act = 1; m_phase = 0; m_first = 0; m_count = 0; m_owner = 0;
        m_inp_d = 0; m_en_d = 0; m_outd = 0; m_outn = 0; m_seen = 0; m_period = 0;
    endtask

    // owner: 0 no pulse in flight, 1 pulse belongs to outd, 2 pulse belongs to outn
    task automatic model_step();
        bit en_rise, rise, to_d;
        int top, s, pos, next_act;
        top      = m_act - 1;
        s        = m_first ? top : (m_phase < top ? m_phase : top);
        en_rise  = enable && !m_en_d;
        rise     = enable && inp && !m_inp_d;
        pos      = en_rise ? s : m_count;
        to_d     = rise && (pos == top);
        next_act = (!enable || to_d) ? m_shadow : m_act;
        if (div_wstb) m_shadow = (divisor == 0) ? 1 : int'(divisor);
        if (phase_wstb) m_phase = int'(phase);
        if (first_wstb) m_first = first;
        m_act = next_act;
        if (enable) m_count = rise ? (pos + 1) % (top + 1) : pos;
        if (!enable || !inp) m_owner = 0;
        else if (rise) m_owner = to_d ? 1 : 2;
        m_cyc++;
        if (en_rise) begin m_seen = 0; m_period = 0; end
        if (m_owner == 1 && !m_outd) begin
            if (m_seen) m_period = (m_cyc - m_last > MAXV) ? MAXV : m_cyc - m_last;
            m_seen = 1;
            m_last = m_cyc;
        end
        m_outd = (m_owner == 1);
        m_outn = (m_owner == 2);
        m_inp_d = inp;
        m_en_d  = enable;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        div_wstb = 0; phase_wstb = 0; first_wstb = 0;
        check("model_outd", int'(outd), int'(m_outd));
        check("model_outn", int'(outn), int'(m_outn));
        check("model_count", int'(count), m_count);
`ifdef PDIV_PERIOD_MEAS_EN
        check("model_period", int'(period), m_period);
`else
        check("model_period", int'(period), 0);
`endif
    endtask

    task automatic configure(input int d, input int p, input bit f);
        enable = 0; inp = 0;
        divisor = W'(d); phase = W'(p); first = f;
        div_wstb = 1; phase_wstb = 1; first_wstb = 1;
        tick(); tick();
        enable = 1;
        tick();
    endtask

    task automatic pulse(input string name, input bit exp_d);
        inp = 1;
        tick();
        check({name, "_outd"}, int'(outd), int'(exp_d));
        check({name, "_outn"}, int'(outn), int'(!exp_d));
        inp = 0;
        tick();
    endtask

    initial begin
        tbl = '{'{1,0,0,0,0},
                '{1,1,0,1,1}, '{1,0,0,0,1}, '{1,1,0,1,2}, '{1,0,0,0,2}, '{1,1,1,0,0}, '{1,0,0,0,0},
                '{1,1,0,1,1}, '{1,0,0,0,1}, '{1,1,0,1,2}, '{1,0,0,0,2}, '{1,1,1,0,0}, '{1,0,0,0,0},
                '{1,1,0,1,1}, '{1,0,0,0,1}, '{1,1,0,1,2}, '{1,0,0,0,2}, '{1,1,1,0,0}, '{1,0,0,0,0}};
        model_reset();
        m_cyc = 0; m_last = 0;
        #3;
        check("reset_outd", int'(outd), 0);
        check("reset_outn", int'(outn), 0);
        check("reset_count", int'(count), 0);
        check("reset_period", int'(period), 0);
        #9 reset_n = 1;

        // divide by 3 from phase 0
        divisor = 8'd3; div_wstb = 1;
        tick(); tick();
        for (int i = 0; i < 19; i++) begin
            enable = (tbl[i].en != 0);
            inp    = (tbl[i].in != 0);
            tick();
            check($sformatf("tbl%0d_outd", i), int'(outd), tbl[i].d);
            check($sformatf("tbl%0d_outn", i), int'(outn), tbl[i].n);
            check($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
        end

        // first pulse override, then programmed phase
        configure(4, 0, 1);
        pulse("fp1", 1); pulse("fp2", 0); pulse("fp3", 0); pulse("fp4", 0); pulse("fp5", 1);
        configure(4, 2, 0);
        pulse("ph1", 0); pulse("ph2", 1); pulse("ph3", 0); pulse("ph4", 0); pulse("ph5", 0); pulse("ph6", 1);

        // divisor written mid-cycle waits for the wrap
        configure(2, 0, 0);
        pulse("dv1", 0);
        divisor = 8'd5; div_wstb = 1;
        tick();
        pulse("dv2", 1);
        for (int i = 3; i <= 6; i++) pulse($sformatf("dv%0d", i), 0);
        pulse("dv7", 1);
        configure(0, 0, 0);
        pulse("dz1", 1); pulse("dz2", 1); pulse("dz3", 1);

        // enable dropped mid-pulse, re-enabled with input high
        configure(3, 1, 0);
        pulse("en1", 0);
        inp = 1; tick();
        check("en2_outd", int'(outd), 1);
        enable = 0; tick();
        check("endrop_outd", int'(outd), 0);
        check("endrop_count", int'(count), 0);
        tick();
        check("endrop_hold", int'(count), 0);
        enable = 1; tick();
        check("reen_outd", int'(outd), 0);
        check("reen_outn", int'(outn), 0);
        check("reen_count", int'(count), 1);
        inp = 0; tick();
        pulse("reen_next", 0);
        check("reen_next_count", int'(count), 2);

        // enable and input rising together use the start value
        enable = 0; inp = 0; phase = 8'd2; phase_wstb = 1;
        tick(); tick();
        enable = 1; inp = 1; tick();
        check("sim_outd", int'(outd), 1);
        check("sim_outn", int'(outn), 0);
        check("sim_count", int'(count), 0);
        inp = 0; tick();

        // asynchronous reset in the middle of a pulse
        configure(3, 0, 0);
        inp = 1; tick();
        check("pre_rst_outn", int'(outn), 1);
        #2 reset_n = 0;
        #1;
        check("rst_outd", int'(outd), 0);
        check("rst_outn", int'(outn), 0);
        check("rst_count", int'(count), 0);
        model_reset();
        enable = 0; inp = 0;
        #3 reset_n = 1;
        inp = 1; tick();
        check("post_rst_outd", int'(outd), 0);
        check("post_rst_outn", int'(outn), 0);
        inp = 0; tick();
        enable = 1; tick();
        pulse("post_rst_en", 1);

        // period of outd with a pulse every 10 cycles and divide by 2
        configure(2, 0, 0);
        for (int k = 0; k < 4; k++) begin
            inp = 1; tick();
            inp = 0;
            repeat (9) tick();
        end
`ifdef PDIV_PERIOD_MEAS_EN
        check("period_20", int'(period), 20);
`else
        check("period_off", int'(period), 0);
`endif

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) inp = ~inp;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) begin divisor = W'($urandom_range(0, 6)); div_wstb = 1; end
            if ($urandom_range(0, 29) == 0) begin phase = W'($urandom_range(0, 7)); phase_wstb = 1; end
            if ($urandom_range(0, 49) == 0) begin first = 1'($urandom_range(0, 1)); first_wstb = 1; end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
